// File: rtl/horloge_pkg.sv
// horloge_pkg: shared widths, limits and FSM state for the horloge tick receiver
package horloge_pkg;
  localparam int HOURS_W = 5;
  localparam int MIN_SEC_W = 6;
  localparam int MAX_HOURS = 23;
  localparam int MAX_MIN_SEC = 59;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/horloge_sync_edge.sv
// horloge_sync_edge: synchronizes toggle_in and emits a registered one-cycle tick per level change while armed
module horloge_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic toggle_in,
  input  logic arm,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync;
  logic last;
  // last follows the synchronized level even while disarmed, so arming never sees a stale level
  always_ff @(posedge clock)
    if (reset) begin
      sync <= '0;
      last <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle_in};
      last <= sync[SYNC_STAGES-1];
      tick <= arm & (sync[SYNC_STAGES-1] ^ last);
    end
endmodule

// File: rtl/horloge_tick_receiver.sv
// horloge_tick_receiver: toggle-line tick receiver with seconds prescaler and hh:mm:ss clock; HORLOGE_ALARM_EN adds the hh:mm alarm
module horloge_tick_receiver
  import horloge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TICKS_PER_SECOND = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 toggle_in,
  input  logic                 set_valid,
  output logic                 set_ready,
  input  logic [HOURS_W-1:0]   set_hours,
  input  logic [MIN_SEC_W-1:0] set_minutes,
  input  logic [MIN_SEC_W-1:0] set_seconds,
  output logic                 set_error,
  output logic [HOURS_W-1:0]   hours,
  output logic [MIN_SEC_W-1:0] minutes,
  output logic [MIN_SEC_W-1:0] seconds,
  output logic                 second_tick,
  output logic                 day_rollover
`ifdef HORLOGE_ALARM_EN
  ,
  input  logic                 alarm_enable,
  input  logic [HOURS_W-1:0]   alarm_hours,
  input  logic [MIN_SEC_W-1:0] alarm_minutes,
  output logic                 alarm
`endif
);
  localparam int PW = TICKS_PER_SECOND > 1 ? $clog2(TICKS_PER_SECOND) : 1;
  state_t state, state_n;
  logic [2:0] init_cnt;
  logic [PW-1:0] pre;
  logic raw_tick, inc, load, fields_ok, sec_w, min_w, hr_w;
  logic [HOURS_W-1:0] hours_n;
  logic [MIN_SEC_W-1:0] minutes_n, seconds_n;
  horloge_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .toggle_in(toggle_in),
    .arm(state == RUN),
    .tick(raw_tick)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_n;
      init_cnt <= state == INIT ? init_cnt + 3'd1 : init_cnt;
    end
  always_comb state_n = (state == INIT && init_cnt == 3'(SYNC_STAGES)) ? RUN : state;
  assign set_ready = state == RUN;
  always_comb begin
    load = set_valid & set_ready;
    fields_ok = set_hours <= HOURS_W'(MAX_HOURS) && set_minutes <= MIN_SEC_W'(MAX_MIN_SEC)
             && set_seconds <= MIN_SEC_W'(MAX_MIN_SEC);
    inc = raw_tick && pre == PW'(TICKS_PER_SECOND - 1);
    sec_w = seconds == MIN_SEC_W'(MAX_MIN_SEC);
    min_w = minutes == MIN_SEC_W'(MAX_MIN_SEC);
    hr_w = hours == HOURS_W'(MAX_HOURS);
    seconds_n = sec_w ? '0 : seconds + 6'd1;
    minutes_n = !sec_w ? minutes : min_w ? '0 : minutes + 6'd1;
    hours_n = !(sec_w && min_w) ? hours : hr_w ? '0 : hours + 5'd1;
  end
  // a load handshake owns the cycle: any tick maturing alongside it is dropped
  always_ff @(posedge clock)
    if (reset) begin
      pre <= '0;
      hours <= '0;
      minutes <= '0;
      seconds <= '0;
      set_error <= 1'b0;
      second_tick <= 1'b0;
      day_rollover <= 1'b0;
    end else begin
      set_error <= load && !fields_ok;
      second_tick <= !load && inc;
      day_rollover <= !load && inc && sec_w && min_w && hr_w;
      if (load) begin
        if (fields_ok) begin
          pre <= '0;
          hours <= set_hours;
          minutes <= set_minutes;
          seconds <= set_seconds;
        end
      end else if (raw_tick) begin
        pre <= inc ? '0 : pre + PW'(1);
        if (inc) begin
          hours <= hours_n;
          minutes <= minutes_n;
          seconds <= seconds_n;
        end
      end
    end
`ifdef HORLOGE_ALARM_EN
  always_ff @(posedge clock)
    if (reset) alarm <= 1'b0;
    else alarm <= !load && inc && alarm_enable && seconds_n == '0
                  && minutes_n == alarm_minutes && hours_n == alarm_hours;
`endif
endmodule

// File: tb/tb_horloge_tick_receiver.sv
// tb_horloge_tick_receiver: randomized and directed checks of two receivers (1 and 4 ticks per second) against a seconds-of-day model
module tb_horloge_tick_receiver;
  logic clock = 1'b0, reset = 1'b1, toggle_in = 1'b0, set_valid = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0, set_seconds = '0;
  logic ready1, ready4, err1, err4, st1, st4, roll1, roll4;
  logic [4:0] h1, h4;
  logic [5:0] m1, m4, s1, s4;
  int checks = 0, errors = 0;
  int t1 = 0, t4 = 0, pre4 = 0;
  int ex_st1 = 0, ex_st4 = 0, ex_roll1 = 0, ex_roll4 = 0, ex_err = 0, ex_al1 = 0, ex_al4 = 0;
  int c_st1 = 0, c_st4 = 0, c_roll1 = 0, c_roll4 = 0, c_err1 = 0, c_err4 = 0, c_al1 = 0, c_al4 = 0;
`ifdef HORLOGE_ALARM_EN
  logic alarm_enable = 1'b0, al1, al4;
  logic [4:0] alarm_hours = '0;
  logic [5:0] alarm_minutes = '0;
`endif
  always #5 clock = ~clock;
  horloge_tick_receiver #(.SYNC_STAGES(2), .TICKS_PER_SECOND(1)) dut1 (
    .clock(clock), .reset(reset), .toggle_in(toggle_in), .set_valid(set_valid), .set_ready(ready1),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds), .set_error(err1),
    .hours(h1), .minutes(m1), .seconds(s1), .second_tick(st1), .day_rollover(roll1)
`ifdef HORLOGE_ALARM_EN
    , .alarm_enable(alarm_enable), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm(al1)
`endif
  );
  horloge_tick_receiver #(.SYNC_STAGES(2), .TICKS_PER_SECOND(4)) dut4 (
    .clock(clock), .reset(reset), .toggle_in(toggle_in), .set_valid(set_valid), .set_ready(ready4),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds), .set_error(err4),
    .hours(h4), .minutes(m4), .seconds(s4), .second_tick(st4), .day_rollover(roll4)
`ifdef HORLOGE_ALARM_EN
    , .alarm_enable(alarm_enable), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm(al4)
`endif
  );
  always @(negedge clock) begin
    c_st1 += int'(st1);
    c_st4 += int'(st4);
    c_roll1 += int'(roll1);
    c_roll4 += int'(roll4);
    c_err1 += int'(err1);
    c_err4 += int'(err4);
`ifdef HORLOGE_ALARM_EN
    c_al1 += int'(al1);
    c_al4 += int'(al4);
`endif
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic adv(inout int t, inout int n_st, inout int n_roll, inout int n_al);
    t = (t + 1) % 86400;
    n_st++;
    if (t == 0) n_roll++;
`ifdef HORLOGE_ALARM_EN
    if (alarm_enable && t % 60 == 0 && t / 60 == int'(alarm_hours) * 60 + int'(alarm_minutes)) n_al++;
`endif
  endtask
  task automatic model_tick();
    adv(t1, ex_st1, ex_roll1, ex_al1);
    pre4++;
    if (pre4 == 4) begin
      pre4 = 0;
      adv(t4, ex_st4, ex_roll4, ex_al4);
    end
  endtask
  task automatic model_load(input int h, input int m, input int s);
    if (h <= 23 && m <= 59 && s <= 59) begin
      t1 = h * 3600 + m * 60 + s;
      t4 = t1;
      pre4 = 0;
    end else ex_err++;
  endtask
  task automatic toggle(input int gap);
    toggle_in = ~toggle_in;
    model_tick();
    repeat (gap) step();
  endtask
  task automatic load(input int h, input int m, input int s);
    set_hours = 5'(h);
    set_minutes = 6'(m);
    set_seconds = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    model_load(h, m, s);
  endtask
  task automatic chk_time(input string tag);
    chk({tag, "_h1"}, int'(h1), t1 / 3600);
    chk({tag, "_m1"}, int'(m1), (t1 / 60) % 60);
    chk({tag, "_s1"}, int'(s1), t1 % 60);
    chk({tag, "_h4"}, int'(h4), t4 / 3600);
    chk({tag, "_m4"}, int'(m4), (t4 / 60) % 60);
    chk({tag, "_s4"}, int'(s4), t4 % 60);
  endtask
  initial begin
    toggle_in = 1'b1;
    repeat (3) step();
    chk("rst_ready1", int'(ready1), 0);
    chk_time("rst");
    reset = 1'b0;
    step();
    chk("init1_ready", int'(ready1), 0);
    step();
    chk("init2_ready", int'(ready1), 0);
    step();
    chk("run_ready1", int'(ready1), 1);
    chk("run_ready4", int'(ready4), 1);
    repeat (5) step();
    chk("no_spurious_tick", c_st1, 0);
    chk_time("post_init");
    toggle_in = 1'b0;
    model_tick();
    step();
    chk("lat_n0", int'(st1), 0);
    repeat (2) step();
    chk("lat_n2_tick", int'(st1), 0);
    chk("lat_n2_sec", int'(s1), 0);
    step();
    chk("lat_n3_tick", int'(st1), 1);
    chk("lat_n3_sec", int'(s1), 1);
    step();
    chk("lat_n4_tick", int'(st1), 0);
    load(23, 59, 59);
    chk_time("load_235959");
    toggle(3);
    step();
    chk("wrap_tick", int'(st1), 1);
    chk("wrap_roll", int'(roll1), 1);
    chk("wrap_sec", int'(s1), 0);
    chk_time("wrap");
    step();
    chk("wrap_roll_off", int'(roll1), 0);
    load(12, 60, 0);
    chk("bad_err", int'(err1), 1);
    chk("bad_err4", int'(err4), 1);
    chk_time("bad_unchanged");
    step();
    chk("bad_err_off", int'(err1), 0);
    load(12, 30, 0);
    chk("good_err", int'(err1), 0);
    chk_time("good_1230");
    while (pre4 != 3) toggle(3);
    repeat (2) step();
    toggle_in = ~toggle_in;
    repeat (3) step();
    set_hours = 5'd8;
    set_minutes = 6'd15;
    set_seconds = 6'd30;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    model_load(8, 15, 30);
    chk("coll_tick1", int'(st1), 0);
    chk("coll_tick4", int'(st4), 0);
    chk_time("coll");
    repeat (3) toggle(3);
    step();
    chk("pre_cleared_s4", int'(s4), 30);
    toggle(4);
    chk("pre_wrap_s4", int'(s4), 31);
    chk_time("pre_wrap");
`ifdef HORLOGE_ALARM_EN
    alarm_hours = 5'd7;
    alarm_minutes = 6'd0;
    alarm_enable = 1'b1;
    load(6, 59, 59);
    toggle(3);
    step();
    chk("alarm_on1", int'(al1), 1);
    chk("alarm_on4", int'(al4), 0);
    step();
    chk("alarm_off", int'(al1), 0);
    alarm_enable = 1'b0;
    load(6, 59, 59);
    toggle(3);
    step();
    chk("alarm_dis", int'(al1), 0);
    alarm_hours = 5'd0;
    alarm_minutes = 6'd0;
    alarm_enable = 1'b1;
`endif
    repeat (40) begin
      int k;
      repeat ($urandom_range(1, 6)) toggle(int'($urandom_range(2, 4)));
      repeat (4) step();
      chk_time("rand");
      case ($urandom_range(0, 3))
        0: load(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
        1: load(23, 59, int'($urandom_range(50, 59)));
        2: begin
          k = int'($urandom_range(0, 2));
          load(k == 0 ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)),
               k == 1 ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59)),
               k == 2 ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59)));
        end
        default: ;
      endcase
      step();
    end
    repeat (4) step();
    chk_time("final");
    chk("cnt_tick1", c_st1, ex_st1);
    chk("cnt_tick4", c_st4, ex_st4);
    chk("cnt_roll1", c_roll1, ex_roll1);
    chk("cnt_roll4", c_roll4, ex_roll4);
    chk("cnt_err1", c_err1, ex_err);
    chk("cnt_err4", c_err4, ex_err);
`ifdef HORLOGE_ALARM_EN
    chk("cnt_alarm1", c_al1, ex_al1);
    chk("cnt_alarm4", c_al4, ex_al4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
